// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op encodings and FSM states.
package hilo_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_WB
    } state_t;

    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

    function automatic logic op_is_div(input logic [1:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// Bit-serial datapath: shift-add multiply on a 2*WIDTH accumulator, restoring divide
// with the quotient shifted through the accumulator's low half.
module muldiv_iter_core #(
    parameter int WIDTH = 32,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_load,
    input  logic               i_is_div,
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    input  logic               i_step,
    output logic [2*WIDTH-1:0] o_prod,
    output logic [WIDTH-1:0]   o_quo,
    output logic [WIDTH-1:0]   o_rem,
    output logic [CW-1:0]      o_count
);

    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_m;
    logic [WIDTH-1:0]   r_rem;
    logic [CW-1:0]      r_count;
    logic               r_is_div;

    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH:0]     w_div_shift;
    logic [WIDTH:0]     w_div_diff;
    logic               w_div_ok;

    // r_m holds the multiplicand (multiply) or the divisor (divide)
    always_comb begin
        w_mul_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_m} : '0);
        w_div_shift = {r_rem, r_acc[WIDTH-1]};
        w_div_diff  = w_div_shift - {1'b0, r_m};
        w_div_ok    = !w_div_diff[WIDTH];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc    <= '0;
            r_m      <= '0;
            r_rem    <= '0;
            r_count  <= '0;
            r_is_div <= 1'b0;
        end else if (i_load) begin
            r_is_div <= i_is_div;
            r_m      <= i_is_div ? i_b : i_a;
            r_acc    <= {{WIDTH{1'b0}}, (i_is_div ? i_a : i_b)};
            r_rem    <= '0;
            r_count  <= CW'(WIDTH);
        end else if (i_step) begin
            r_count <= r_count - CW'(1);
            if (r_is_div) begin
                r_rem              <= w_div_ok ? w_div_diff[WIDTH-1:0] : w_div_shift[WIDTH-1:0];
                r_acc[WIDTH-1:0]   <= {r_acc[WIDTH-2:0], w_div_ok};
            end else begin
                r_acc <= {w_mul_sum, r_acc[WIDTH-1:1]};
            end
        end
    end

    assign o_prod  = r_acc;
    assign o_quo   = r_acc[WIDTH-1:0];
    assign o_rem   = r_rem;
    assign o_count = r_count;

endmodule

// File: rtl/hilo_muldiv.sv
// HI/LO multiply/divide unit: FSM, sign handling and architectural HI/LO registers
// around the bit-serial muldiv_iter_core.
module hilo_muldiv
    import hilo_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out_hi,
    output logic [WIDTH-1:0] out_lo
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t             r_state;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [WIDTH-1:0]   r_a_raw;
    logic               r_is_div;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_div0;
    logic               r_done;

    logic               w_signed;
    logic               w_accept;
    logic               w_abort;
    logic               w_step;
    logic               w_last;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_res_hi;
    logic [WIDTH-1:0]   w_res_lo;
    logic [CW-1:0]      w_count;

    assign w_signed = op_is_signed(op);
    assign w_a_mag  = (w_signed && src_a[WIDTH-1]) ? -src_a : src_a;
    assign w_b_mag  = (w_signed && src_b[WIDTH-1]) ? -src_b : src_b;

    assign w_accept = (r_state == ST_IDLE) && start && !cancel;
    assign w_abort  = cancel || wr_hi || wr_lo;
    assign w_step   = (r_state == ST_CALC) && !w_abort;
    assign w_last   = (w_count == CW'(1));

    muldiv_iter_core #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_accept),
        .i_is_div (op_is_div(op)),
        .i_a      (w_a_mag),
        .i_b      (w_b_mag),
        .i_step   (w_step),
        .o_prod   (w_prod),
        .o_quo    (w_quo),
        .o_rem    (w_rem),
        .o_count  (w_count)
    );

    // Magnitude results get their signs back here; MIN / -1 falls out naturally
    // because negating 2^(WIDTH-1) wraps to itself.
    assign w_prod_fix = r_neg_q ? -w_prod : w_prod;

    always_comb begin
        w_res_hi = w_prod_fix[2*WIDTH-1:WIDTH];
        w_res_lo = w_prod_fix[WIDTH-1:0];
        if (r_is_div) begin
            if (r_div0) begin
                w_res_hi = r_a_raw;
                w_res_lo = '1;
            end else begin
                w_res_hi = r_neg_r ? -w_rem : w_rem;
                w_res_lo = r_neg_q ? -w_quo : w_quo;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_hi     <= '0;
            r_lo     <= '0;
            r_a_raw  <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_div0   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (wr_hi) r_hi <= wr_data;
            if (wr_lo) r_lo <= wr_data;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state  <= ST_CALC;
                        r_is_div <= op_is_div(op);
                        r_neg_q  <= w_signed && (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
                        r_neg_r  <= w_signed && src_a[WIDTH-1];
                        r_div0   <= (src_b == '0);
                        r_a_raw  <= src_a;
                    end
                end
                ST_CALC: begin
                    if (w_abort)     r_state <= ST_IDLE;
                    else if (w_last) r_state <= ST_WB;
                end
                ST_WB: begin
                    r_state <= ST_IDLE;
                    if (!w_abort) begin
                        r_hi   <= w_res_hi;
                        r_lo   <= w_res_lo;
                        r_done <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy   = (r_state != ST_IDLE);
    assign done   = r_done;
    assign out_hi = r_hi;
    assign out_lo = r_lo;

endmodule
